// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, default opcodes and the IR capture pattern.
// Used by the TAP, its FSM, the GPIO scan-chain wrappers and the bench.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam logic [3:0]  DEF_OP_EXTEST    = 4'h0;
    localparam logic [3:0]  DEF_OP_SCAN_N    = 4'h2;
    localparam logic [3:0]  DEF_OP_IDCODE    = 4'he;
    localparam logic [3:0]  DEF_OP_BYPASS    = 4'hf;
    localparam logic [31:0] DEF_IDCODE      = 32'h1000_0001;
    localparam logic [1:0]  IR_CAPTURE      = 2'b01;

endpackage

// File: rtl/jtag_tap_if.sv
// TAP pins plus the strobes/selects handed to the downstream GPIO scan chain.
// tms/tdi are sampled on posedge tck, tdo/tdo_oe launch on negedge; there is no valid/ready pair.
interface jtag_tap_if;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic       gpios_tdo;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       scan_n_ir;
    logic       extest_ir;
    logic [3:0] tap_state;

    modport slave (
        input  tms, tdi, gpios_tdo,
        output tdo, tdo_oe, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, tap_state
    );

    modport master (
        output tms, tdi, gpios_tdo,
        input  tdo, tdo_oe, capture_dr, shift_dr, update_dr, scan_n_ir, extest_ir, tap_state
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, next-state table and state decodes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output tap_state_e state,
    output logic       is_capture_dr,
    output logic       is_shift_dr,
    output logic       is_update_dr,
    output logic       is_capture_ir,
    output logic       is_shift_ir,
    output logic       is_update_ir,
    output logic       is_test_logic_reset
);

    // Five tms=1 clocks reach Test-Logic-Reset from anywhere purely through this table.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            case (state)
                TEST_LOGIC_RESET: state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state <= tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        state <= tms ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state <= tms ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         state <= tms ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         state <= tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state <= tms ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         state <= tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state <= tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state <= tms ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         state <= tms ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         state <= tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state <= tms ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         state <= tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state <= tms ? SELECT_DR : RUN_TEST_IDLE;
                default:          state <= TEST_LOGIC_RESET;
            endcase
        end
    end

    assign is_capture_dr       = (state == CAPTURE_DR);
    assign is_shift_dr         = (state == SHIFT_DR);
    assign is_update_dr        = (state == UPDATE_DR);
    assign is_capture_ir       = (state == CAPTURE_IR);
    assign is_shift_ir         = (state == SHIFT_IR);
    assign is_update_ir        = (state == UPDATE_IR);
    assign is_test_logic_reset = (state == TEST_LOGIC_RESET);

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP: instruction register, IDCODE/BYPASS data registers and the tdo mux
// in front of the GPIO boundary-scan chain.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int                 IR_BITS      = 4,
    parameter logic [31:0]        IDCODE_VALUE = DEF_IDCODE,
    parameter logic [IR_BITS-1:0] OP_EXTEST    = IR_BITS'(DEF_OP_EXTEST),
    parameter logic [IR_BITS-1:0] OP_SCAN_N    = IR_BITS'(DEF_OP_SCAN_N),
    parameter logic [IR_BITS-1:0] OP_IDCODE    = IR_BITS'(DEF_OP_IDCODE),
    parameter logic [IR_BITS-1:0] OP_BYPASS    = '1
) (
    input logic        tck,
    input logic        reset,
    jtag_tap_if.slave  jif
);

    localparam logic [IR_BITS-1:0] IR_CAPTURE_EXT = IR_BITS'(IR_CAPTURE);

    tap_state_e         state;
    logic               is_capture_dr, is_shift_dr, is_update_dr;
    logic               is_capture_ir, is_shift_ir, is_update_ir, is_test_logic_reset;
    logic [IR_BITS-1:0] ir_shift;
    logic [IR_BITS-1:0] ir_active;
    logic [31:0]        idcode_reg;
    logic               bypass_reg;
    logic               sel_idcode, sel_extest, sel_scan_n, sel_bypass;
    logic               dr_tdo;
    logic               tdo_q, tdo_oe_q;

    jtag_tap_fsm u_fsm (
        .tck                 (tck),
        .reset               (reset),
        .tms                 (jif.tms),
        .state               (state),
        .is_capture_dr       (is_capture_dr),
        .is_shift_dr         (is_shift_dr),
        .is_update_dr        (is_update_dr),
        .is_capture_ir       (is_capture_ir),
        .is_shift_ir         (is_shift_ir),
        .is_update_ir        (is_update_ir),
        .is_test_logic_reset (is_test_logic_reset)
    );

    assign sel_idcode = (ir_active == OP_IDCODE);
    assign sel_extest = (ir_active == OP_EXTEST);
    assign sel_scan_n = (ir_active == OP_SCAN_N);
    // OP_BYPASS and every undefined opcode land here.
    assign sel_bypass = !(sel_idcode || sel_extest || sel_scan_n);

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            ir_shift   <= '0;
            ir_active  <= OP_IDCODE;
            idcode_reg <= '0;
            bypass_reg <= 1'b0;
        end else begin
            if (is_capture_ir)
                ir_shift <= IR_CAPTURE_EXT;
            else if (is_shift_ir)
                ir_shift <= {jif.tdi, ir_shift[IR_BITS-1:1]};

            if (is_test_logic_reset)
                ir_active <= OP_IDCODE;
            else if (is_update_ir)
                ir_active <= ir_shift;

            if (sel_idcode && is_capture_dr)
                idcode_reg <= IDCODE_VALUE;
            else if (sel_idcode && is_shift_dr)
                idcode_reg <= {jif.tdi, idcode_reg[31:1]};

            if (sel_bypass && is_capture_dr)
                bypass_reg <= 1'b0;
            else if (sel_bypass && is_shift_dr)
                bypass_reg <= jif.tdi;
        end
    end

    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_idcode)
            dr_tdo = idcode_reg[0];
        else if (sel_extest || sel_scan_n)
            dr_tdo = jif.gpios_tdo;
    end

    // Launch on the falling edge so the far end samples a settled tdo on the next rising edge.
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (is_shift_ir) begin
            tdo_q    <= ir_shift[0];
            tdo_oe_q <= 1'b1;
        end else if (is_shift_dr) begin
            tdo_q    <= dr_tdo;
            tdo_oe_q <= 1'b1;
        end else begin
            tdo_oe_q <= 1'b0;
        end
    end

    assign jif.tdo        = tdo_q;
    assign jif.tdo_oe     = tdo_oe_q;
    assign jif.capture_dr = is_capture_dr;
    assign jif.shift_dr   = is_shift_dr;
    assign jif.update_dr  = is_update_dr;
    assign jif.scan_n_ir  = sel_scan_n;
    assign jif.extest_ir  = sel_extest;
    assign jif.tap_state  = state;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: IR/DR scans, instruction selects, strobe widths,
// reset mid-scan and the five-ones return to Test-Logic-Reset from every state.
module tb_jtag_tap;
    import jtag_pkg::*;

    logic tck;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n_cap, n_sh, n_upd;

    jtag_tap_if tif();

    jtag_tap dut (
        .tck   (tck),
        .reset (reset),
        .jif   (tif.slave)
    );

    // clock / reset
    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One tck period: drive, rising edge, falling edge, then settle for sampling.
    task automatic cycle(input logic tms_v, input logic tdi_v);
        tif.tms = tms_v;
        tif.tdi = tdi_v;
        @(posedge tck);
        #1;
        @(negedge tck);
        #1;
        if (tif.capture_dr) n_cap++;
        if (tif.shift_dr)   n_sh++;
        if (tif.update_dr)  n_upd++;
    endtask

    // Starts in Run-Test/Idle, ends in Update-IR.
    task automatic ir_scan(input logic [3:0] din, output logic [3:0] dout);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = tif.tdo;
            cycle(i == 3, din[i]);
        end
        cycle(1'b1, 1'b0);
    endtask

    // Starts and ends in Run-Test/Idle; gpat is presented on gpios_tdo one bit per shift cycle.
    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] gpat,
                           output logic [31:0] dout);
        dout  = '0;
        n_cap = 0;
        n_sh  = 0;
        n_upd = 0;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        tif.gpios_tdo = gpat[0];
        cycle(1'b0, 1'b0);
        check("dr_shift_oe", tif.tdo_oe, 1);
        for (int i = 0; i < n; i++) begin
            dout[i] = tif.tdo;
            if (i < 31) tif.gpios_tdo = gpat[i+1];
            cycle(i == n - 1, din[i]);
        end
        check("dr_exit1_state", tif.tap_state, EXIT1_DR);
        check("dr_exit1_oe", tif.tdo_oe, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    int         path_len[16];
    logic [7:0] path_bits[16];
    tap_state_e path_tgt[16];

    initial begin
        logic [31:0] d32;
        logic [3:0]  d4;

        n_checks = 0;
        n_pass   = 0;
        n_cap    = 0;
        n_sh     = 0;
        n_upd    = 0;
        reset         = 1'b1;
        tif.tms       = 1'b1;
        tif.tdi       = 1'b0;
        tif.gpios_tdo = 1'b0;

        // Paths from Test-Logic-Reset, tms bits LSB first.
        path_tgt[0]  = TEST_LOGIC_RESET; path_len[0]  = 0; path_bits[0]  = 8'b0;
        path_tgt[1]  = RUN_TEST_IDLE;    path_len[1]  = 1; path_bits[1]  = 8'b0;
        path_tgt[2]  = SELECT_DR;        path_len[2]  = 2; path_bits[2]  = 8'b10;
        path_tgt[3]  = CAPTURE_DR;       path_len[3]  = 3; path_bits[3]  = 8'b010;
        path_tgt[4]  = SHIFT_DR;         path_len[4]  = 4; path_bits[4]  = 8'b0010;
        path_tgt[5]  = EXIT1_DR;         path_len[5]  = 4; path_bits[5]  = 8'b1010;
        path_tgt[6]  = PAUSE_DR;         path_len[6]  = 5; path_bits[6]  = 8'b01010;
        path_tgt[7]  = EXIT2_DR;         path_len[7]  = 6; path_bits[7]  = 8'b101010;
        path_tgt[8]  = UPDATE_DR;        path_len[8]  = 5; path_bits[8]  = 8'b11010;
        path_tgt[9]  = SELECT_IR;        path_len[9]  = 3; path_bits[9]  = 8'b110;
        path_tgt[10] = CAPTURE_IR;       path_len[10] = 4; path_bits[10] = 8'b0110;
        path_tgt[11] = SHIFT_IR;         path_len[11] = 5; path_bits[11] = 8'b00110;
        path_tgt[12] = EXIT1_IR;         path_len[12] = 5; path_bits[12] = 8'b10110;
        path_tgt[13] = PAUSE_IR;         path_len[13] = 6; path_bits[13] = 8'b010110;
        path_tgt[14] = EXIT2_IR;         path_len[14] = 7; path_bits[14] = 8'b1010110;
        path_tgt[15] = UPDATE_IR;        path_len[15] = 6; path_bits[15] = 8'b110110;

        // reset state
        #12;
        check("rst_state", tif.tap_state, TEST_LOGIC_RESET);
        check("rst_tdo", tif.tdo, 0);
        check("rst_tdo_oe", tif.tdo_oe, 0);
        check("rst_strobes", {tif.capture_dr, tif.shift_dr, tif.update_dr}, 0);
        check("rst_selects", {tif.scan_n_ir, tif.extest_ir}, 0);
        @(negedge tck);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b0);
        check("rti_after_rst", tif.tap_state, RUN_TEST_IDLE);

        // IDCODE straight out of reset
        dr_scan(32, 32'h0, 32'h0, d32);
        check("idcode_out", d32, 32'h1000_0001);
        check("idcode_n_cap", n_cap, 1);
        check("idcode_n_shift", n_sh, 32);
        check("idcode_n_upd", n_upd, 1);

        // undefined opcode 4'h5 -> BYPASS
        ir_scan(4'h5, d4);
        check("ir_capture_5", d4, 4'h1);
        cycle(1'b0, 1'b0);
        dr_scan(8, 32'hA5, 32'h0, d32);
        check("bypass_out", d32, 32'h4A);

        // SCAN_N
        ir_scan(4'h2, d4);
        check("ir_capture_2", d4, 4'h1);
        check("scan_n_in_upd_ir", tif.scan_n_ir, 0);
        cycle(1'b0, 1'b0);
        check("scan_n_after_upd", tif.scan_n_ir, 1);
        check("extest_under_scan_n", tif.extest_ir, 0);
        dr_scan(5, 32'h16, 32'h0D, d32);
        check("scan_n_gpio_path", d32, 32'h0D);
        check("scan_n_n_cap", n_cap, 1);
        check("scan_n_n_shift", n_sh, 5);
        check("scan_n_n_upd", n_upd, 1);
        check("scan_n_stable", tif.scan_n_ir, 1);

        // EXTEST
        ir_scan(4'h0, d4);
        check("ir_capture_0", d4, 4'h1);
        check("extest_in_upd_ir", tif.extest_ir, 0);
        check("scan_n_in_upd_ir2", tif.scan_n_ir, 1);
        cycle(1'b0, 1'b0);
        check("extest_after_upd", tif.extest_ir, 1);
        check("scan_n_after_extest", tif.scan_n_ir, 0);
        dr_scan(4, 32'h0, 32'hB, d32);
        check("extest_gpio_path", d32, 32'hB);
        check("extest_n_shift", n_sh, 4);
        check("tdo_hold", tif.tdo, 1);

        // reset in the middle of Shift-DR
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check("pre_rst_shift", tif.tap_state, SHIFT_DR);
        n_upd = 0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", tif.tap_state, TEST_LOGIC_RESET);
        check("mid_rst_strobes", {tif.capture_dr, tif.shift_dr, tif.update_dr}, 0);
        check("mid_rst_oe", tif.tdo_oe, 0);
        check("mid_rst_extest", tif.extest_ir, 0);
        @(negedge tck);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b0);
        check("post_rst_state", tif.tap_state, RUN_TEST_IDLE);
        check("post_rst_no_upd", n_upd, 0);
        check("post_rst_oe", tif.tdo_oe, 0);
        dr_scan(32, 32'h0, 32'h0, d32);
        check("post_rst_idcode", d32, 32'h1000_0001);

        // five tms=1 clocks from every state
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
        check("tlr_from_rti", tif.tap_state, TEST_LOGIC_RESET);
        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < path_len[s]; j++) cycle(path_bits[s][j], 1'b0);
            check($sformatf("reach_%0d", s), tif.tap_state, path_tgt[s]);
            for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
            check($sformatf("tlr_from_%0d", s), tif.tap_state, TEST_LOGIC_RESET);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
